change_expect_monitor: RTL

Synthesizable hardware counterpart of the bench's change-expectation checks; it sits directly downstream of the monitored signal and consumes it. Once armed, it waits for the monitored bus to change value within a programmable cycle window. It reports pass or fail with a result code and the cycle offset of the match. The report feeds status/scoreboard logic and drives bench pass/fail prints.

---
 rtl/change_expect_monitor.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/change_expect_monitor.sv
// Change-expectation monitor: once armed, waits for the monitored bus to
// change within a programmable cycle window and reports pass/fail.
module change_expect_monitor #(
    parameter int WIDTH      = 1,
    parameter int CNT_W      = 16,
    parameter int EARLY_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig,
    input  logic             arm,
    input  logic             abort,
    input  logic [CNT_W-1:0] win_min,
    input  logic [CNT_W-1:0] win_max,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [2:0]       result_code,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [2:0] RC_NONE    = 3'd0;
    localparam logic [2:0] RC_MATCH   = 3'd1;
    localparam logic [2:0] RC_TIMEOUT = 3'd2;
    localparam logic [2:0] RC_EARLY   = 3'd3;
    localparam logic [2:0] RC_BADWIN  = 3'd4;
    localparam logic [2:0] RC_ABORT   = 3'd5;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [2:0]       code_q, code_d;
    logic [CNT_W-1:0] match_q, match_d;

    logic             changed;
    logic [CNT_W-1:0] k;
    logic             in_win;

    assign changed = (sig != sig_q);
    // Offset of the current edge; saturates so an unbounded wait never wraps.
    assign k       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign in_win  = (k >= min_q) && ((max_q == '0) || (k <= max_q));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        min_d   = min_q;
        max_d   = max_q;
        done_d  = 1'b0;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        code_d  = code_q;
        match_d = match_q;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    min_d   = (win_min == '0) ? CNT_ONE : win_min;
                    max_d   = win_max;
                    code_d  = RC_NONE;
                    match_d = '0;
                end
            end
            WAIT: begin
                cnt_d = k;
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    code_d  = RC_ABORT;
                    match_d = k;
                end else if (k == CNT_ONE && max_q != '0 && max_q < min_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    code_d  = RC_BADWIN;
                    match_d = k;
                end else if (changed && k < min_q && EARLY_FAIL != 0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    code_d  = RC_EARLY;
                    match_d = k;
                end else if (changed && in_win) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                    code_d  = RC_MATCH;
                    match_d = k;
                end else if (max_q != '0 && k == max_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    code_d  = RC_TIMEOUT;
                    match_d = k;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= RC_NONE;
            match_q <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
            match_q <= match_d;
        end
    end

    assign busy        = (state_q == WAIT);
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign result_code = code_q;
    assign match_cnt   = match_q;

endmodule
